prog_timer: RTL and testbench
=============================

# prog_timer

Parametrised programmable counter/timer, the successor to the fixed-terminal static counter. It provides a runtime-loadable terminal count, an up/down direction, an integer prescaler, periodic or one-shot mode, and a registered terminal-tick pulse. It sits beside control logic as a general timebase for baud, refresh and timeout generation.

## Interface
- WIDTH, 16: counter width in bits.
- PRESCALE_BITS, 8: prescaler register width.
- DEFAULT_TC, 32767: terminal count after reset; must fit in WIDTH bits.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- enable  input  1  count qualifier; low freezes the counter and the prescaler.
- clear  input  1  synchronous restart to the start value; keeps configuration.
- load  input  1  synchronous capture of tc_in, prescale_in, oneshot_in and down_in, plus restart.
- tc_in  input  WIDTH  terminal count to load.
- prescale_in  input  PRESCALE_BITS  prescale divisor minus 1.
- oneshot_in  input  1  1 = one-shot, 0 = periodic.
- down_in  input  1  1 = count down, 0 = count up.
- count  output  WIDTH  current count.
- tick  output  1  one-cycle pulse on a terminal step.
- done  output  1  sticky one-shot completion flag.
- running  output  1  high while in RUN.

## Operation
- Config registers: tc_reg, psc_reg, oneshot_reg, down_reg.
- Start value: 0 when counting up, tc_reg when counting down.
- End value: tc_reg when counting up, 0 when counting down.
- Control priority per cycle: load > clear > enable.
- load:
  - Captures all config inputs.
  - Sets count to the start value computed from the newly loaded values.
  - Sets psc_cnt to 0, done to 0, tick to 0, state to IDLE.
  - Takes effect mid-run.
- clear: same as load, but config registers are unchanged.
- Prescaler:
  - psc_cnt increments on each enabled cycle while state is not DONE.
  - When psc_cnt == psc_reg, a step occurs and psc_cnt returns to 0.
  - psc_reg = 0 gives one step per enabled cycle.
- States:
  - IDLE: reached via reset, load or clear. The first step moves to RUN.
  - RUN: steps advance count.
  - DONE: count and prescaler frozen. Exits only via load, clear or nrst.
- Step when count != end value: count += 1 (up) or -= 1 (down), modulo 2^WIDTH not reachable in normal operation.
- Step when count == end value (terminal step):
  - tick goes high on the next cycle.
  - Periodic mode: count reloads the start value.
  - One-shot mode: count holds the end value, done is set, state goes to DONE.
- Period: (tc_reg+1)·(psc_reg+1) enabled cycles between ticks.
- tc_reg = 0: every step is terminal. count stays 0 and tick fires on every step (periodic mode).
- running = (state == RUN). In IDLE, count equals the start value.
- No combinational path from inputs to outputs; all outputs are registered.

## Timing
- Reset values:
  - count = 0, tick = 0, done = 0, running = 0, state = IDLE.
  - tc_reg = DEFAULT_TC, psc_reg = 0, oneshot_reg = 0, down_reg = 0.
- nrst asserted mid-operation forces the reset values immediately, independent of clk.
- Step latency: count changes on the same edge that samples the qualifying enable. No added pipeline.
- Terminal step: tick is high for exactly one cycle, coincident with the reloaded or held count value.
- done rises on the same edge as tick and stays high until load, clear or nrst.
- running falls on the edge that enters DONE.
- load or clear on the same edge as a terminal step: load/clear wins. tick stays 0 and done stays 0.
- enable low on a would-be step cycle: no step. psc_cnt holds.

## Test plan
- Up, periodic: load tc=3, psc=0, enable held -> count 0,1,2,3,0,1…; tick high on each cycle where count shows 0 after a wrap, every 4 cycles.
- Prescaled down: load tc=2, psc=1, down=1 -> count 2,2,1,1,0,0,2…; tick period 6 cycles.
- One-shot: load tc=5, oneshot=1 -> count reaches 5 and holds; one tick; done=1, running=0; clear -> count=0, done=0, state IDLE.
- Enable gating plus simultaneous events: toggle enable every other cycle with tc=3 -> tick period 8 clocks. Assert clear on the terminal-step edge -> no tick, count=0.
- Reset mid-run: tc=100, at count=57 pulse nrst low asynchronously -> count=0, tick=0, done=0. After release with enable high, count runs to 32767 (DEFAULT_TC) before the first tick.
- tc=0, up, periodic -> count stays 0; tick high every enabled cycle after the first step.

Source files
------------

// File: rtl/prog_timer.sv
// prog_timer: programmable up/down counter/timer with prescaler, periodic or one-shot mode
module prog_timer #(
    parameter int WIDTH         = 16,
    parameter int PRESCALE_BITS = 8,
    parameter int DEFAULT_TC    = 32767
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     load,
    input  logic [WIDTH-1:0]         tc_in,
    input  logic [PRESCALE_BITS-1:0] prescale_in,
    input  logic                     oneshot_in,
    input  logic                     down_in,
    output logic [WIDTH-1:0]         count,
    output logic                     tick,
    output logic                     done,
    output logic                     running
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   r_state;
    logic [WIDTH-1:0]         r_tc;
    logic [WIDTH-1:0]         r_count;
    logic [PRESCALE_BITS-1:0] r_psc;
    logic [PRESCALE_BITS-1:0] r_psc_cnt;
    logic                     r_oneshot;
    logic                     r_down;
    logic                     r_tick;
    logic                     r_done;
    logic                     r_running;

    logic [WIDTH-1:0] w_start;
    logic [WIDTH-1:0] w_end;
    logic             w_advance;
    logic             w_step;
    logic             w_terminal;

    assign w_start    = r_down ? r_tc : '0;
    assign w_end      = r_down ? '0 : r_tc;
    assign w_advance  = enable && (r_state != DONE);
    assign w_step     = w_advance && (r_psc_cnt == r_psc);
    assign w_terminal = (r_count == w_end);

    assign count   = r_count;
    assign tick    = r_tick;
    assign done    = r_done;
    assign running = r_running;

    // Config capture, prescaler, count stepping and state machine; load beats clear beats enable.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_tc      <= WIDTH'(DEFAULT_TC);
            r_psc     <= '0;
            r_oneshot <= 1'b0;
            r_down    <= 1'b0;
            r_psc_cnt <= '0;
            r_count   <= '0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
            r_state   <= IDLE;
        end else if (load) begin
            r_tc      <= tc_in;
            r_psc     <= prescale_in;
            r_oneshot <= oneshot_in;
            r_down    <= down_in;
            r_psc_cnt <= '0;
            r_count   <= down_in ? tc_in : '0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
            r_state   <= IDLE;
        end else if (clear) begin
            r_psc_cnt <= '0;
            r_count   <= w_start;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
            r_state   <= IDLE;
        end else begin
            r_tick <= 1'b0;
            if (w_advance && !w_step)
                r_psc_cnt <= r_psc_cnt + PRESCALE_BITS'(1);
            if (w_step) begin
                r_psc_cnt <= '0;
                if (w_terminal && r_oneshot) begin
                    r_tick    <= 1'b1;
                    r_done    <= 1'b1;
                    r_running <= 1'b0;
                    r_state   <= DONE;
                end else begin
                    r_tick    <= w_terminal;
                    r_count   <= w_terminal ? w_start : (r_down ? r_count - WIDTH'(1) : r_count + WIDTH'(1));
                    r_running <= 1'b1;
                    r_state   <= RUN;
                end
            end
        end
    end
endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: directed scoreboard bench for prog_timer
module tb_prog_timer;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] tc_in = '0;
    logic [7:0]  prescale_in = '0;
    logic        oneshot_in = 1'b0;
    logic        down_in = 1'b0;
    logic [15:0] count;
    logic        tick;
    logic        done;
    logic        running;

    typedef struct packed {
        logic [15:0] cnt;
        logic        tck;
        logic        dn;
        logic        run;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic [15:0] m_tc, m_cnt;
    logic [7:0]  m_psc, m_pc;
    logic        m_os, m_down, m_tick, m_done;
    int          m_st;

    prog_timer dut (
        .clk(clk), .nrst(nrst), .enable(enable), .clear(clear), .load(load),
        .tc_in(tc_in), .prescale_in(prescale_in), .oneshot_in(oneshot_in), .down_in(down_in),
        .count(count), .tick(tick), .done(done), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tc = 16'd32767; m_psc = '0; m_os = 1'b0; m_down = 1'b0;
        m_pc = '0; m_cnt = '0; m_tick = 1'b0; m_done = 1'b0; m_st = 0;
    endtask

    // Reference behaviour for one clock edge; m_st: 0 idle, 1 run, 2 done
    task automatic model(input logic en, input logic clr, input logic ld);
        logic [15:0] ev;
        m_tick = 1'b0;
        if (ld) begin
            m_tc = tc_in; m_psc = prescale_in; m_os = oneshot_in; m_down = down_in;
            m_cnt = down_in ? tc_in : 16'd0; m_pc = '0; m_done = 1'b0; m_st = 0;
        end else if (clr) begin
            m_cnt = m_down ? m_tc : 16'd0; m_pc = '0; m_done = 1'b0; m_st = 0;
        end else if (en && m_st != 2) begin
            if (m_pc != m_psc) m_pc = m_pc + 8'd1;
            else begin
                m_pc = '0;
                ev = m_down ? 16'd0 : m_tc;
                if (m_cnt == ev) begin
                    m_tick = 1'b1;
                    if (m_os) begin m_done = 1'b1; m_st = 2; end
                    else begin m_cnt = m_down ? m_tc : 16'd0; m_st = 1; end
                end else begin
                    m_cnt = m_down ? m_cnt - 16'd1 : m_cnt + 16'd1;
                    m_st = 1;
                end
            end
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("count", 32'(count), 32'(e.cnt));
            chk("tick", 32'(tick), 32'(e.tck));
            chk("done", 32'(done), 32'(e.dn));
            chk("running", 32'(running), 32'(e.run));
        end
    endtask

    task automatic cyc(input logic en, input logic clr, input logic ld);
        exp_t e;
        enable = en; clear = clr; load = ld;
        model(en, clr, ld);
        e.cnt = m_cnt; e.tck = m_tick; e.dn = m_done; e.run = (m_st == 1);
        sb.push_back(e);
        @(posedge clk); #1;
        compare_head();
    endtask

    task automatic do_load(input logic [15:0] tc, input logic [7:0] psc, input logic os, input logic dn);
        tc_in = tc; prescale_in = psc; oneshot_in = os; down_in = dn;
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        exp_t e;
        int up_cnt[8]   = '{1, 2, 3, 0, 1, 2, 3, 0};
        int up_tck[8]   = '{0, 0, 0, 1, 0, 0, 0, 1};
        int dn_cnt[12]  = '{2, 1, 1, 0, 0, 2, 2, 1, 1, 0, 0, 2};
        int dn_tck[12]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        int tick_at[$];

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        e.cnt = m_cnt; e.tck = m_tick; e.dn = m_done; e.run = 1'b0;
        sb.push_back(e);
        compare_head();
        nrst = 1'b1;

        // Up, periodic, tc=3
        do_load(16'd3, 8'd0, 1'b0, 1'b0);
        chk("up_load_count", 32'(count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("up_seq_count", 32'(count), 32'(up_cnt[i]));
            chk("up_seq_tick", 32'(tick), 32'(up_tck[i]));
        end

        // Prescaled down, tc=2, psc=1
        do_load(16'd2, 8'd1, 1'b0, 1'b1);
        chk("dn_load_count", 32'(count), 32'd2);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("dn_seq_count", 32'(count), 32'(dn_cnt[i]));
            chk("dn_seq_tick", 32'(tick), 32'(dn_tck[i]));
        end

        // One-shot, tc=5
        do_load(16'd5, 8'd0, 1'b1, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        chk("os_pre_count", 32'(count), 32'd5);
        chk("os_pre_tick", 32'(tick), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("os_term_tick", 32'(tick), 32'd1);
        chk("os_term_done", 32'(done), 32'd1);
        chk("os_term_running", 32'(running), 32'd0);
        chk("os_term_count", 32'(count), 32'd5);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        chk("os_hold_count", 32'(count), 32'd5);
        chk("os_hold_tick", 32'(tick), 32'd0);
        chk("os_hold_done", 32'(done), 32'd1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("os_clear_count", 32'(count), 32'd0);
        chk("os_clear_done", 32'(done), 32'd0);
        chk("os_clear_running", 32'(running), 32'd0);

        // Enable toggling, tc=3 -> tick every 8 clocks
        do_load(16'd3, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc((i % 2) == 0, 1'b0, 1'b0);
            if (tick) tick_at.push_back(i);
        end
        chk("gate_tick_count", 32'(tick_at.size()), 32'd2);
        if (tick_at.size() >= 2) chk("gate_tick_period", 32'(tick_at[1] - tick_at[0]), 32'd8);

        // Clear on the terminal-step edge
        do_load(16'd3, 8'd0, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        chk("clr_pre_count", 32'(count), 32'd3);
        cyc(1'b1, 1'b1, 1'b0);
        chk("clr_term_count", 32'(count), 32'd0);
        chk("clr_term_tick", 32'(tick), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("clr_after_count", 32'(count), 32'd1);

        // tc=0 -> tick on every enabled cycle
        do_load(16'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("tc0_count", 32'(count), 32'd0);
            chk("tc0_tick", 32'(tick), 32'd1);
        end

        // Asynchronous reset mid-run, then default terminal count
        do_load(16'd100, 8'd0, 1'b0, 1'b0);
        repeat (57) cyc(1'b1, 1'b0, 1'b0);
        chk("rst_pre_count", 32'(count), 32'd57);
        nrst = 1'b0;
        #1;
        model_reset();
        chk("rst_async_count", 32'(count), 32'd0);
        chk("rst_async_tick", 32'(tick), 32'd0);
        chk("rst_async_done", 32'(done), 32'd0);
        chk("rst_async_running", 32'(running), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_count", 32'(count), 32'd0);
        nrst = 1'b1;
        repeat (32767) cyc(1'b1, 1'b0, 1'b0);
        chk("deftc_pre_count", 32'(count), 32'd32767);
        chk("deftc_pre_tick", 32'(tick), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("deftc_tick", 32'(tick), 32'd1);
        chk("deftc_wrap_count", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
